// File: rtl/uart_reg_bank.sv
// APB-side register bank for a UART: control, baud divisor, status with sticky
// error flags, TX/RX FIFO data ports and an interrupt enable register.
module uart_reg_bank #(
  parameter logic [15:0] BAUD_RST = 16'd54,
  parameter int          AW       = 8
) (
  input  logic        pclk,
  input  logic        preset,
  input  logic        wr_en_i,
  input  logic        rd_en_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        pready_o,
  input  logic        tx_full_i,
  input  logic        tx_empty_i,
  output logic        tx_push_o,
  output logic [7:0]  tx_data_o,
  input  logic        rx_full_i,
  input  logic        rx_empty_i,
  input  logic [7:0]  rx_data_i,
  output logic        rx_pop_o,
  input  logic        rx_ovr_i,
  input  logic        perr_i,
  output logic        tx_en_o,
  output logic        rx_en_o,
  output logic        par_en_o,
  output logic        par_odd_o,
  output logic        stop2_o,
  output logic [15:0] baud_div_o,
  output logic        irq_o
);

  localparam logic [AW-1:0] OFF_CTRL = AW'(8'h00);
  localparam logic [AW-1:0] OFF_BAUD = AW'(8'h04);
  localparam logic [AW-1:0] OFF_STAT = AW'(8'h08);
  localparam logic [AW-1:0] OFF_TX   = AW'(8'h0C);
  localparam logic [AW-1:0] OFF_RX   = AW'(8'h10);
  localparam logic [AW-1:0] OFF_IER  = AW'(8'h14);

  logic [4:0]    ctrl_q;
  logic [15:0]   baud_q;
  logic [2:0]    ier_q;
  logic [2:0]    sticky_q;
  logic          mapped;
  logic [AW-1:0] off;
  logic          wr_ctrl, wr_baud, wr_stat, wr_tx, wr_ier;
  logic          rd_go, rd_rx;
  logic [2:0]    sticky_set, sticky_clr;
  logic [31:0]   rd_mux;
  logic          unused_wdata;

  assign unused_wdata = ^wdata_i[31:16];

  assign mapped  = (addr_i[31:AW] == '0) && (addr_i[1:0] == 2'b00);
  assign off     = addr_i[AW-1:0];
  assign wr_ctrl = wr_en_i && mapped && (off == OFF_CTRL);
  assign wr_baud = wr_en_i && mapped && (off == OFF_BAUD);
  assign wr_stat = wr_en_i && mapped && (off == OFF_STAT);
  assign wr_tx   = wr_en_i && mapped && (off == OFF_TX);
  assign wr_ier  = wr_en_i && mapped && (off == OFF_IER);
  // A write always takes priority over a colliding read strobe.
  assign rd_go   = rd_en_i && !wr_en_i;
  assign rd_rx   = rd_go && mapped && (off == OFF_RX) && !rx_empty_i;

  assign sticky_set = {wr_tx && tx_full_i, perr_i, rx_ovr_i};
  assign sticky_clr = wr_stat ? wdata_i[6:4] : 3'b000;

  always_comb begin
    rd_mux = 32'd0;
    if (mapped) begin
      case (off)
        OFF_CTRL: rd_mux = {27'd0, ctrl_q};
        OFF_BAUD: rd_mux = {16'd0, baud_q};
        OFF_STAT: rd_mux = {25'd0, sticky_q, rx_empty_i, rx_full_i, tx_empty_i, tx_full_i};
        OFF_RX:   rd_mux = rx_empty_i ? 32'd0 : {24'd0, rx_data_i};
        OFF_IER:  rd_mux = {29'd0, ier_q};
        default:  rd_mux = 32'd0;
      endcase
    end
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      ctrl_q    <= '0;
      baud_q    <= BAUD_RST;
      ier_q     <= '0;
      sticky_q  <= '0;
      rdata_o   <= '0;
      pready_o  <= 1'b0;
      tx_push_o <= 1'b0;
      tx_data_o <= '0;
      rx_pop_o  <= 1'b0;
      irq_o     <= 1'b0;
    end else begin
      pready_o  <= 1'b1;
      if (wr_ctrl) ctrl_q <= wdata_i[4:0];
      if (wr_baud) baud_q <= wdata_i[15:0];
      if (wr_ier)  ier_q  <= wdata_i[2:0];
      // Set beats clear when both land in the same cycle.
      sticky_q  <= (sticky_q & ~sticky_clr) | sticky_set;
      tx_push_o <= wr_tx && !tx_full_i;
      if (wr_tx && !tx_full_i) tx_data_o <= wdata_i[7:0];
      rx_pop_o  <= rd_rx;
      if (rd_go) rdata_o <= rd_mux;
      irq_o     <= (ier_q[0] & tx_empty_i) | (ier_q[1] & ~rx_empty_i) |
                   (ier_q[2] & |sticky_q);
    end
  end

  assign tx_en_o    = ctrl_q[0];
  assign rx_en_o    = ctrl_q[1];
  assign par_en_o   = ctrl_q[2];
  assign par_odd_o  = ctrl_q[3];
  assign stop2_o    = ctrl_q[4];
  assign baud_div_o = baud_q;

endmodule

// File: tb/tb_uart_reg_bank.sv
// Directed and randomized checks of uart_reg_bank against a register-map model.
module tb_uart_reg_bank;

  logic        pclk = 1'b0;
  logic        preset, wr_en_i, rd_en_i;
  logic [31:0] addr_i, wdata_i, rdata_o;
  logic        pready_o, tx_full_i, tx_empty_i, tx_push_o;
  logic [7:0]  tx_data_o, rx_data_i;
  logic        rx_full_i, rx_empty_i, rx_pop_o, rx_ovr_i, perr_i;
  logic        tx_en_o, rx_en_o, par_en_o, par_odd_o, stop2_o, irq_o;
  logic [15:0] baud_div_o;

  int n_cmp = 0;
  int n_err = 0;

  uart_reg_bank dut (
    .pclk(pclk), .preset(preset), .wr_en_i(wr_en_i), .rd_en_i(rd_en_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .rdata_o(rdata_o), .pready_o(pready_o),
    .tx_full_i(tx_full_i), .tx_empty_i(tx_empty_i), .tx_push_o(tx_push_o),
    .tx_data_o(tx_data_o), .rx_full_i(rx_full_i), .rx_empty_i(rx_empty_i),
    .rx_data_i(rx_data_i), .rx_pop_o(rx_pop_o), .rx_ovr_i(rx_ovr_i),
    .perr_i(perr_i), .tx_en_o(tx_en_o), .rx_en_o(rx_en_o), .par_en_o(par_en_o),
    .par_odd_o(par_odd_o), .stop2_o(stop2_o), .baud_div_o(baud_div_o),
    .irq_o(irq_o)
  );

  always #5 pclk = ~pclk;

  // Reference model: word-indexed register array plus write masks.
  logic [31:0] m_rw [6];
  logic [31:0] wmask [6] = '{32'h1F, 32'hFFFF, 32'h0, 32'h0, 32'h0, 32'h7};
  logic [2:0]  m_stk;
  logic [31:0] m_rdata;
  logic        m_pready, m_push, m_pop, m_irq;
  logic [7:0]  m_txd;

  task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    logic        ok;
    int          idx;
    logic [31:0] view [6];
    logic [2:0]  clr, setb;
    logic        irq_n;
    if (preset) begin
      m_rw = '{32'h0, 32'h36, 32'h0, 32'h0, 32'h0, 32'h0};
      m_stk = 0; m_rdata = 0; m_pready = 0; m_push = 0; m_pop = 0; m_irq = 0; m_txd = 0;
      return;
    end
    ok  = (addr_i[31:8] == 24'd0) && (addr_i[1:0] == 2'b00) && (addr_i[7:2] < 6);
    idx = int'(addr_i[7:2]);
    view[0] = m_rw[0];
    view[1] = m_rw[1];
    view[2] = {25'd0, m_stk, rx_empty_i, rx_full_i, tx_empty_i, tx_full_i};
    view[3] = 32'd0;
    view[4] = rx_empty_i ? 32'd0 : {24'd0, rx_data_i};
    view[5] = m_rw[5];
    irq_n = (m_rw[5][0] && tx_empty_i) || (m_rw[5][1] && !rx_empty_i) ||
            (m_rw[5][2] && (m_stk != 0));
    clr = 0; setb = {1'b0, perr_i, rx_ovr_i};
    m_push = 0; m_pop = 0;
    if (wr_en_i) begin
      if (ok) begin
        if (wmask[idx] != 0) m_rw[idx] = wdata_i & wmask[idx];
        if (idx == 2) clr = wdata_i[6:4];
        if (idx == 3) begin
          if (tx_full_i) setb[2] = 1'b1;
          else begin m_push = 1; m_txd = wdata_i[7:0]; end
        end
      end
    end else if (rd_en_i) begin
      m_rdata = ok ? view[idx] : 32'd0;
      m_pop = ok && (idx == 4) && !rx_empty_i;
    end
    m_stk = (m_stk & ~clr) | setb;
    m_pready = 1;
    m_irq = irq_n;
  endtask

  task automatic step();
    model_edge();
    @(posedge pclk);
    #1;
    chk("outputs",
        {rdata_o, pready_o, tx_push_o, tx_data_o, rx_pop_o, stop2_o, par_odd_o,
         par_en_o, rx_en_o, tx_en_o, baud_div_o, irq_o},
        {m_rdata, m_pready, m_push, m_txd, m_pop, m_rw[0][4:0], m_rw[1][15:0], m_irq});
  endtask

  task automatic do_wr(input logic [31:0] a, input logic [31:0] d);
    wr_en_i = 1; addr_i = a; wdata_i = d;
    step();
    wr_en_i = 0;
  endtask

  task automatic do_rd(input logic [31:0] a);
    rd_en_i = 1; addr_i = a;
    step();
    rd_en_i = 0;
  endtask

  logic [31:0] addr_tab [8] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14, 32'h18, 32'h100};

  initial begin
    preset = 1; wr_en_i = 0; rd_en_i = 0; addr_i = 0; wdata_i = 0;
    tx_full_i = 0; tx_empty_i = 1; rx_full_i = 0; rx_empty_i = 1; rx_data_i = 0;
    rx_ovr_i = 0; perr_i = 0;
    step();
    step();
    chk("rst_pready", 65'(pready_o), 65'd0);
    chk("rst_rdata", 65'(rdata_o), 65'd0);
    chk("rst_baud", 65'(baud_div_o), 65'h36);
    preset = 0;
    step();
    chk("pready_up", 65'(pready_o), 65'd1);
    do_rd(32'h4);
    chk("baud_read", 65'({rdata_o, pready_o, irq_o}), 65'({32'h36, 1'b1, 1'b0}));

    do_wr(32'hC, 32'hA5);
    chk("tx_push", 65'({tx_push_o, tx_data_o}), 65'({1'b1, 8'hA5}));
    step();
    chk("tx_push_end", 65'({tx_push_o, tx_data_o}), 65'({1'b0, 8'hA5}));
    tx_full_i = 1; tx_empty_i = 0;
    do_wr(32'hC, 32'h5A);
    chk("tx_drop", 65'({tx_push_o, tx_data_o}), 65'({1'b0, 8'hA5}));
    do_rd(32'h8);
    chk("status_ovf", 65'(rdata_o), 65'h49);
    tx_full_i = 0; tx_empty_i = 1;
    do_wr(32'h8, 32'h40);
    do_rd(32'h8);
    chk("status_w1c", 65'(rdata_o), 65'h0A);

    rx_empty_i = 0; rx_data_i = 8'h3C;
    do_rd(32'h10);
    chk("rx_read", 65'({rdata_o, rx_pop_o}), 65'({32'h3C, 1'b1}));
    step();
    chk("rx_pop_end", 65'(rx_pop_o), 65'd0);
    rx_empty_i = 1;
    do_rd(32'h10);
    chk("rx_empty_read", 65'({rdata_o, rx_pop_o}), 65'({32'h0, 1'b0}));

    do_wr(32'h14, 32'h4);
    perr_i = 1;
    step();
    perr_i = 0;
    step();
    chk("irq_rise", 65'(irq_o), 65'd1);
    do_wr(32'h8, 32'h20);
    step();
    chk("irq_fall", 65'(irq_o), 65'd0);
    perr_i = 1;
    do_wr(32'h8, 32'h20);
    perr_i = 0;
    do_rd(32'h8);
    chk("set_wins", 65'(rdata_o), 65'h2A);
    do_wr(32'h8, 32'h70);
    do_wr(32'h14, 32'h0);

    do_wr(32'h0, 32'h1B);
    do_wr(32'h18, 32'hFFFFFFFF);
    do_wr(32'h100, 32'hFFFFFFFF);
    chk("unmapped_wr", 65'({stop2_o, par_odd_o, par_en_o, rx_en_o, tx_en_o, baud_div_o}),
        65'({5'h1B, 16'h36}));
    do_rd(32'h0);
    chk("ctrl_read", 65'(rdata_o), 65'h1B);
    do_rd(32'h18);
    chk("rd_0x18", 65'(rdata_o), 65'd0);
    do_rd(32'h14);
    do_rd(32'h100);
    chk("rd_0x100", 65'(rdata_o), 65'd0);
    do_rd(32'h0);
    do_rd(32'hC);
    chk("rd_txdata", 65'(rdata_o), 65'd0);

    do_rd(32'h0);
    wr_en_i = 1; rd_en_i = 1; addr_i = 32'h4; wdata_i = 32'h1234;
    step();
    wr_en_i = 0; rd_en_i = 0;
    chk("wr_rd_collide", 65'({baud_div_o, rdata_o}), 65'({16'h1234, 32'h1B}));

    preset = 1;
    wr_en_i = 1; addr_i = 32'hC; wdata_i = 32'h77;
    step();
    wr_en_i = 0; preset = 0;
    chk("rst_cancel", 65'({tx_push_o, pready_o, tx_data_o}), 65'd0);

    for (int i = 0; i < 600; i++) begin
      int op;
      preset     = ($urandom_range(0, 63) == 0);
      op         = $urandom_range(0, 7);
      wr_en_i    = (op <= 2) || (op == 6);
      rd_en_i    = (op >= 3 && op <= 6);
      addr_i     = ($urandom_range(0, 9) == 0) ? $urandom : addr_tab[$urandom_range(0, 7)];
      wdata_i    = $urandom;
      tx_full_i  = $urandom_range(0, 1);
      tx_empty_i = $urandom_range(0, 1);
      rx_full_i  = $urandom_range(0, 1);
      rx_empty_i = $urandom_range(0, 1);
      rx_data_i  = 8'($urandom);
      perr_i     = ($urandom_range(0, 7) == 0);
      rx_ovr_i   = ($urandom_range(0, 7) == 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
